// File: rtl/rvx_pkg.sv
// Shared types and constants for the rvx instruction prefetch buffer.
// Used by rvx_instruction_prefetch_buffer and its entry RAM.
package rvx_pkg;

    localparam int RVX_XLEN        = 32;
    localparam int RVX_INSTR_BYTES = 4;

    // Width of the in-flight and drop counters. It covers responses still
    // outstanding from several back-to-back redirects.
    localparam int RVX_CNT_W = 8;

    // One prefetch slot: fetch address, returned word and a data-present flag.
    typedef struct packed {
        logic [RVX_XLEN-1:0] addr;
        logic [RVX_XLEN-1:0] data;
        logic                filled;
    } rvx_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [RVX_XLEN-1:0] rvx_word_align(input logic [RVX_XLEN-1:0] a);
        return {a[RVX_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rvx_prefetch_checker.sv
// Simulation checks for the prefetch buffer memory interface.
// A read response must never arrive while nothing is outstanding.
module rvx_prefetch_checker #(
    parameter int CNT_W = 8
) (
    input logic             clock,
    input logic             reset,
    input logic             mem_rresponse,
    input logic [CNT_W-1:0] inflight
);

    // A response with no outstanding request is a memory protocol error.
    a_no_orphan_response : assert property (
        @(posedge clock) disable iff (reset)
        mem_rresponse |-> (inflight != '0)
    );

endmodule

// File: rtl/rvx_prefetch_entry_ram.sv
// FIFO_DEPTH x 65-bit prefetch slot array.
// A slot is reserved with its address when the request is issued. It is
// filled with data when the response returns and read at the head.
module rvx_prefetch_entry_ram
    import rvx_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                reserve_en,
    input  logic [IDX_W-1:0]    reserve_idx,
    input  logic [RVX_XLEN-1:0] reserve_addr,
    input  logic                fill_en,
    input  logic [IDX_W-1:0]    fill_idx,
    input  logic [RVX_XLEN-1:0] fill_data,
    input  logic [IDX_W-1:0]    read_idx,
    output rvx_entry_t          read_entry
);

    rvx_entry_t entry_r [FIFO_DEPTH];

    // Slot storage: reset zeroes everything, clear only drops the data-present flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_r[i].filled <= 1'b0;
            end
        end else begin
            if (reserve_en) begin
                entry_r[reserve_idx].addr   <= reserve_addr;
                entry_r[reserve_idx].filled <= 1'b0;
            end
            if (fill_en) begin
                entry_r[fill_idx].data   <= fill_data;
                entry_r[fill_idx].filled <= 1'b1;
            end
        end
    end

    assign read_entry = entry_r[read_idx];

endmodule

// File: rtl/rvx_instruction_prefetch_buffer.sv
// Instruction prefetch buffer. It keeps up to FIFO_DEPTH words requested or
// buffered ahead of the core, and it redirects on flush.
// Optional statistics counters: define RVX_PREFETCH_STATS_EN.
module rvx_instruction_prefetch_buffer
    import rvx_pkg::*;
#(
    parameter int                  FIFO_DEPTH    = 4,
    parameter logic [RVX_XLEN-1:0] RESET_ADDRESS = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [RVX_XLEN-1:0] flush_address,
    output logic [RVX_XLEN-1:0] mem_address,
    output logic                mem_rrequest,
    input  logic [RVX_XLEN-1:0] mem_rdata,
    input  logic                mem_rresponse,
    output logic [RVX_XLEN-1:0] instr_address,
    output logic [RVX_XLEN-1:0] instr_data,
    output logic                instr_valid,
`ifdef RVX_PREFETCH_STATS_EN
    output logic [31:0]         stat_flushes,
    output logic [31:0]         stat_discarded,
`endif
    input  logic                instr_ready
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [RVX_XLEN-1:0]  fetch_pc_r;
    logic [IDX_W-1:0]     issue_ptr_r;
    logic [IDX_W-1:0]     fill_ptr_r;
    logic [IDX_W-1:0]     read_ptr_r;
    logic [OCC_W-1:0]     occupancy_r;
    logic [RVX_CNT_W-1:0] inflight_r;
    logic [RVX_CNT_W-1:0] drop_r;

    logic       issue_s;
    logic       resp_ok_s;
    logic       fill_s;
    logic       discard_s;
    logic       pop_s;
    rvx_entry_t head_s;

    // Handshake decode for issue, response acceptance and pop.
    always_comb begin
        issue_s   = 1'b0;
        resp_ok_s = 1'b0;
        fill_s    = 1'b0;
        discard_s = 1'b0;
        pop_s     = 1'b0;
        if (!reset) begin
            issue_s   = !flush && (occupancy_r < OCC_W'(FIFO_DEPTH));
            // An orphan response (nothing outstanding) is ignored completely.
            resp_ok_s = mem_rresponse && (inflight_r != '0);
            fill_s    = resp_ok_s && (drop_r == '0) && !flush;
            discard_s = resp_ok_s && !fill_s;
            pop_s     = head_s.filled && instr_ready && !flush;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch PC, ring pointers and the occupancy/in-flight/drop counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r  <= RESET_ADDRESS;
            issue_ptr_r <= '0;
            fill_ptr_r  <= '0;
            read_ptr_r  <= '0;
            occupancy_r <= '0;
            inflight_r  <= '0;
            drop_r      <= '0;
        end else if (flush) begin
            fetch_pc_r  <= rvx_word_align(flush_address);
            issue_ptr_r <= '0;
            fill_ptr_r  <= '0;
            read_ptr_r  <= '0;
            occupancy_r <= '0;
            // The in-flight count already includes responses doomed by an
            // earlier redirect, so every outstanding response is dropped.
            // resp_ok_s implies inflight_r >= 1, so this cannot underflow.
            inflight_r  <= inflight_r - RVX_CNT_W'(resp_ok_s);
            drop_r      <= inflight_r - RVX_CNT_W'(resp_ok_s);
        end else begin
            if (issue_s) begin
                issue_ptr_r <= issue_ptr_r + IDX_W'(1);
                fetch_pc_r  <= fetch_pc_r + RVX_XLEN'(RVX_INSTR_BYTES);
            end
            if (fill_s) begin
                fill_ptr_r <= fill_ptr_r + IDX_W'(1);
            end
            if (pop_s) begin
                read_ptr_r <= read_ptr_r + IDX_W'(1);
            end
            case ({issue_s, pop_s})
                2'b10:   occupancy_r <= occupancy_r + OCC_W'(1);
                2'b01:   occupancy_r <= occupancy_r - OCC_W'(1);
                default: occupancy_r <= occupancy_r;
            endcase
            inflight_r <= inflight_r + RVX_CNT_W'(issue_s) - RVX_CNT_W'(resp_ok_s);
            if (discard_s && (drop_r != '0)) begin
                drop_r <= drop_r - RVX_CNT_W'(1);
            end
        end
    end

    rvx_prefetch_entry_ram #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_entry_ram (
        .clock        (clock),
        .reset        (reset),
        .clear        (flush),
        .reserve_en   (issue_s),
        .reserve_idx  (issue_ptr_r),
        .reserve_addr (fetch_pc_r),
        .fill_en      (fill_s),
        .fill_idx     (fill_ptr_r),
        .fill_data    (mem_rdata),
        .read_idx     (read_ptr_r),
        .read_entry   (head_s)
    );

    rvx_prefetch_checker #(
        .CNT_W (RVX_CNT_W)
    ) u_checker (
        .clock         (clock),
        .reset         (reset),
        .mem_rresponse (mem_rresponse),
        .inflight      (inflight_r)
    );

    assign mem_rrequest  = issue_s;
    assign mem_address   = fetch_pc_r;
    assign instr_valid   = head_s.filled && !reset;
    assign instr_address = head_s.addr;
    assign instr_data    = head_s.data;

`ifdef RVX_PREFETCH_STATS_EN
    logic [31:0] stat_flushes_r;
    logic [31:0] stat_discarded_r;

    // Free-running event counters for redirects and discarded responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_flushes_r   <= 32'd0;
            stat_discarded_r <= 32'd0;
        end else begin
            if (flush) begin
                stat_flushes_r <= stat_flushes_r + 32'd1;
            end
            if (discard_s) begin
                stat_discarded_r <= stat_discarded_r + 32'd1;
            end
        end
    end

    assign stat_flushes   = stat_flushes_r;
    assign stat_discarded = stat_discarded_r;
`endif

endmodule

// File: tb/tb_rvx_instruction_prefetch_buffer.sv
// Directed testbench for rvx_instruction_prefetch_buffer.
// The memory model answers each read with addr ^ 32'hA5A5A5A5 after 1 or 2 cycles.
module tb_rvx_instruction_prefetch_buffer;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] flush_address;
    logic [31:0] mem_address;
    logic        mem_rrequest;
    logic [31:0] mem_rdata;
    logic        mem_rresponse;
    logic [31:0] instr_address;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;
`ifdef RVX_PREFETCH_STATS_EN
    logic [31:0] stat_flushes;
    logic [31:0] stat_discarded;
`endif

    int errors = 0;
    int checks = 0;

    // Memory model state
    logic        lat2;
    logic        p1_v, p2_v;
    logic [31:0] p1_a, p2_a;

    rvx_instruction_prefetch_buffer #(
        .FIFO_DEPTH    (4),
        .RESET_ADDRESS (32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .flush_address (flush_address),
        .mem_address   (mem_address),
        .mem_rrequest  (mem_rrequest),
        .mem_rdata     (mem_rdata),
        .mem_rresponse (mem_rresponse),
        .instr_address (instr_address),
        .instr_data    (instr_data),
        .instr_valid   (instr_valid),
`ifdef RVX_PREFETCH_STATS_EN
        .stat_flushes   (stat_flushes),
        .stat_discarded (stat_discarded),
`endif
        .instr_ready   (instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: a two-stage pipeline that resets along with the DUT.
    always @(posedge clock) begin
        if (reset) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_a <= 32'd0;
            p2_a <= 32'd0;
        end else begin
            p1_v <= mem_rrequest;
            p1_a <= mem_address;
            p2_v <= p1_v;
            p2_a <= p1_a;
        end
    end

    assign mem_rresponse = lat2 ? p2_v : p1_v;
    assign mem_rdata     = (lat2 ? p2_a : p1_a) ^ K;

    typedef struct {
        logic        fl;
        logic [31:0] fa;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_maddr;
        logic        exp_valid;
        logic [31:0] exp_iaddr;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One cycle: drive the inputs at the falling edge, then settle before sampling.
    task automatic cyc(input logic f, input logic [31:0] a, input logic r);
        @(negedge clock);
        reset         = 1'b0;
        flush         = f;
        flush_address = a;
        instr_ready   = r;
        #1;
    endtask

    task automatic hold_reset(input int n, input logic use_lat2);
        @(negedge clock);
        reset       = 1'b1;
        flush       = 1'b0;
        instr_ready = 1'b0;
        lat2        = use_lat2;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_head(input string name, input logic [31:0] a);
        check({name, " valid"}, {31'd0, instr_valid}, 32'd1);
        check({name, " addr"}, instr_address, a);
        check({name, " data"}, instr_data, a ^ K);
    endtask

    initial begin
        // flush, faddr, ready | req, maddr, valid, iaddr
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0010};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0010};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0010};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0010};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0014};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0024, 1'b1, 32'h0000_0018};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0028, 1'b1, 32'h0000_001C};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_002C, 1'b1, 32'h0000_0020};
        vecs[15] = '{1'b1, 32'h203,      1'b1, 1'b0, 32'h0000_0030, 1'b1, 32'h0000_0024};
        vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0200};
        vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_020C, 1'b1, 32'h0000_0204};
        vecs[20] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0000_0210, 1'b1, 32'h0000_0208};
        vecs[21] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
        vecs[22] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[23] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
        vecs[24] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
        vecs[25] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
        vecs[26] = '{1'b1, 32'h40,       1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004};
        vecs[27] = '{1'b1, 32'h81,       1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'h0};
        vecs[28] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0};
        vecs[29] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0084, 1'b0, 32'h0};
        vecs[30] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0088, 1'b1, 32'h0000_0080};
        vecs[31] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_008C, 1'b1, 32'h0000_0084};

        reset         = 1'b1;
        flush         = 1'b0;
        flush_address = 32'd0;
        instr_ready   = 1'b0;
        lat2          = 1'b0;

        // Reset state
        hold_reset(3, 1'b0);
        #1;
        check("reset req", {31'd0, mem_rrequest}, 32'd0);
        check("reset valid", {31'd0, instr_valid}, 32'd0);
        check("reset iaddr", instr_address, 32'd0);
        check("reset idata", instr_data, 32'd0);

        // Streaming, full buffer, flush with a same-cycle response, address wrap, double flush
        for (int i = 0; i < 32; i++) begin
            cyc(vecs[i].fl, vecs[i].fa, vecs[i].rdy);
            check($sformatf("row%0d req", i), {31'd0, mem_rrequest}, {31'd0, vecs[i].exp_req});
            check($sformatf("row%0d maddr", i), mem_address, vecs[i].exp_maddr);
            check($sformatf("row%0d valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("row%0d iaddr", i), instr_address, vecs[i].exp_iaddr);
                check($sformatf("row%0d idata", i), instr_data, vecs[i].exp_iaddr ^ K);
            end
        end
`ifdef RVX_PREFETCH_STATS_EN
        check("tbl stat_flushes", stat_flushes, 32'd4);
        check("tbl stat_discarded", stat_discarded, 32'd3);
`endif

        // Two-cycle memory: flush with two requests in flight, then back-to-back flushes
        hold_reset(2, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        check("e0 maddr", mem_address, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        check("e1 maddr", mem_address, 32'h4);
        cyc(1'b1, 32'h0000_0102, 1'b1);
        check("e2 req", {31'd0, mem_rrequest}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("e3 req", {31'd0, mem_rrequest}, 32'd1);
        check("e3 maddr", mem_address, 32'h100);
        check("e3 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("e4 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("e5 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check_head("e6 head", 32'h100);
`ifdef RVX_PREFETCH_STATS_EN
        check("e6 stat_discarded", stat_discarded, 32'd2);
        check("e6 stat_flushes", stat_flushes, 32'd1);
`endif
        cyc(1'b1, 32'h0000_0300, 1'b1);
        check("e7 req", {31'd0, mem_rrequest}, 32'd0);
        cyc(1'b1, 32'h0000_0400, 1'b1);
        check("e8 maddr", mem_address, 32'h300);
        cyc(1'b0, 32'h0, 1'b1);
        check("e9 maddr", mem_address, 32'h400);
        check("e9 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("e10 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("e11 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check_head("e12 head", 32'h400);
        cyc(1'b0, 32'h0, 1'b1);
        check_head("e13 head", 32'h404);
`ifdef RVX_PREFETCH_STATS_EN
        check("e13 stat_flushes", stat_flushes, 32'd3);
        check("e13 stat_discarded", stat_discarded, 32'd4);
`endif

        // Reset mid-stream with three words buffered
        hold_reset(2, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 1'b0);
        check_head("f3 head", 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("f4 req", {31'd0, mem_rrequest}, 32'd0);
        @(negedge clock);
        #1;
        check("f5 req", {31'd0, mem_rrequest}, 32'd0);
        check("f5 valid", {31'd0, instr_valid}, 32'd0);
        check("f5 iaddr", instr_address, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("f6 req", {31'd0, mem_rrequest}, 32'd1);
        check("f6 maddr", mem_address, 32'h0);
        check("f6 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check("f7 valid", {31'd0, instr_valid}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        check_head("f8 head", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
